// File: rtl/beep_sched.sv
// Buzzer scheduler for the whale-a-mole game: serialises hit/miss/game-over sounds.
// Optional macro BEEP_MELODY_EN: game-over plays a falling 4,3,2,1 melody instead of a flat tone.
module beep_sched #(
    parameter int HIT_TICKS  = 2,
    parameter int MISS_TICKS = 4,
    parameter int NOTE_TICKS = 3
) (
    input  logic       clk_half,
    input  logic       rst,
    input  logic       hit,
    input  logic       miss,
    input  logic       game_over,
    input  logic       mute,
    output logic       beep_en,
    output logic [2:0] tone_sel,
    output logic       busy
);

    // A zero duration would wrap the down-counter, so it is clamped to one tick.
    localparam logic [3:0] HIT_T  = (HIT_TICKS  == 0) ? 4'd1 : 4'(HIT_TICKS);
    localparam logic [3:0] MISS_T = (MISS_TICKS == 0) ? 4'd1 : 4'(MISS_TICKS);
    localparam logic [3:0] NOTE_T = (NOTE_TICKS == 0) ? 4'd1 : 4'(NOTE_TICKS);

    typedef enum logic [2:0] {IDLE, HIT, MISS, OVER, DONE} state_t;

    state_t     state, state_n;
    logic [3:0] cnt, cnt_n;
    logic [1:0] note, note_n;
    logic       hit_r, miss_r, go_r, armed;
    logic       hit_pend, miss_pend, go_pend;
    logic       hit_pend_n, miss_pend_n, go_pend_n;
    logic       hit_edge, miss_edge, go_edge, accept;
    logic       beep_n, busy_n;
    logic [2:0] tone_n;

    // armed stays low for the first tick after reset so a level already high is not an edge.
    assign hit_edge  = armed & hit       & ~hit_r;
    assign miss_edge = armed & miss      & ~miss_r;
    assign go_edge   = armed & game_over & ~go_r;
    assign accept    = (state != OVER) && (state != DONE);

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        note_n      = note;
        hit_pend_n  = hit_pend  | (hit_edge  & accept);
        miss_pend_n = miss_pend | (miss_edge & accept);
        go_pend_n   = go_pend   | (go_edge   & accept);
        case (state)
            IDLE, HIT, MISS: begin
                if (go_pend) begin
                    state_n     = OVER;
                    cnt_n       = NOTE_T - 4'd1;
                    note_n      = 2'd0;
                    go_pend_n   = 1'b0;
                    hit_pend_n  = 1'b0;
                    miss_pend_n = 1'b0;
                end else if (state != IDLE) begin
                    if (cnt == 4'd0) state_n = IDLE;
                    else             cnt_n   = cnt - 4'd1;
                end else if (hit_pend) begin
                    state_n    = HIT;
                    cnt_n      = HIT_T - 4'd1;
                    hit_pend_n = 1'b0;
                end else if (miss_pend) begin
                    state_n     = MISS;
                    cnt_n       = MISS_T - 4'd1;
                    miss_pend_n = 1'b0;
                end
            end
            OVER: begin
                if (cnt != 4'd0) begin
                    cnt_n = cnt - 4'd1;
                end else if (note == 2'd3) begin
                    state_n = DONE;
                end else begin
                    note_n = note + 2'd1;
                    cnt_n  = NOTE_T - 4'd1;
                end
            end
            default: ;
        endcase

        // Outputs are registered from the next state so they line up with it.
        tone_n = 3'd0;
        case (state_n)
            HIT:  tone_n = 3'd4;
            MISS: tone_n = 3'd1;
`ifdef BEEP_MELODY_EN
            OVER: tone_n = 3'd4 - {1'b0, note_n};
`else
            OVER: tone_n = 3'd1;
`endif
            default: ;
        endcase
        beep_n = (state_n == HIT || state_n == MISS || state_n == OVER) & ~mute;
        busy_n = (state_n == HIT || state_n == MISS || state_n == OVER) ||
                 (state_n == IDLE && (hit_pend_n || miss_pend_n || go_pend_n));
    end

    always_ff @(posedge clk_half or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            note      <= 2'd0;
            hit_r     <= 1'b0;
            miss_r    <= 1'b0;
            go_r      <= 1'b0;
            armed     <= 1'b0;
            hit_pend  <= 1'b0;
            miss_pend <= 1'b0;
            go_pend   <= 1'b0;
            beep_en   <= 1'b0;
            tone_sel  <= 3'd0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            note      <= note_n;
            hit_r     <= hit;
            miss_r    <= miss;
            go_r      <= game_over;
            armed     <= 1'b1;
            hit_pend  <= hit_pend_n;
            miss_pend <= miss_pend_n;
            go_pend   <= go_pend_n;
            beep_en   <= beep_n;
            tone_sel  <= tone_n;
            busy      <= busy_n;
        end
    end

endmodule

// File: tb/tb_beep_sched.sv
// Randomised bench for beep_sched against a sound-queue reference model (default parameters).
module tb_beep_sched;

    localparam int HT = 2, MT = 4, NT = 3;

    logic       clk_half = 1'b0;
    logic       rst = 1'b1;
    logic       hit = 1'b0, miss = 1'b0, game_over = 1'b0, mute = 1'b0;
    logic       beep_en, busy;
    logic [2:0] tone_sel;

    int ncmp = 0, nbad = 0;

    beep_sched dut (
        .clk_half (clk_half),
        .rst      (rst),
        .hit      (hit),
        .miss     (miss),
        .game_over(game_over),
        .mute     (mute),
        .beep_en  (beep_en),
        .tone_sel (tone_sel),
        .busy     (busy)
    );

    always #5 clk_half = ~clk_half;

    // Model: what is sounding (0 none, 1 hit, 2 miss, 3 game-over, 4 finished),
    // how many ticks it still owes, and a one-deep request slot per source.
    int kind, left, elapsed;
    bit ph, pm, pg, armed_m, prev_h, prev_m, prev_g;

    task automatic chk(input string tag, input int obs, input int exp);
        ncmp++;
        if (obs != exp) begin
            nbad++;
            $display("FAIL %s @%0t: got %0d, want %0d", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        kind = 0; left = 0; elapsed = 0;
        ph = 0; pm = 0; pg = 0;
        armed_m = 0; prev_h = 0; prev_m = 0; prev_g = 0;
    endtask

    task automatic model_step();
        bit eh, em, eg, acc, clr_h, clr_m, clr_g;
        eh = armed_m && hit && !prev_h;
        em = armed_m && miss && !prev_m;
        eg = armed_m && game_over && !prev_g;
        prev_h = hit; prev_m = miss; prev_g = game_over; armed_m = 1;
        acc = (kind < 3);
        clr_h = 0; clr_m = 0; clr_g = 0;
        if (kind == 3) begin
            elapsed++;
            if (elapsed == 4 * NT) kind = 4;
        end else if (kind < 3) begin
            if (pg) begin
                kind = 3; elapsed = 0;
                clr_h = 1; clr_m = 1; clr_g = 1;
            end else if (kind != 0) begin
                left--;
                if (left == 0) kind = 0;
            end else if (ph) begin
                kind = 1; left = HT; clr_h = 1;
            end else if (pm) begin
                kind = 2; left = MT; clr_m = 1;
            end
        end
        ph = clr_h ? 0 : (ph | (eh & acc));
        pm = clr_m ? 0 : (pm | (em & acc));
        pg = clr_g ? 0 : (pg | (eg & acc));
    endtask

    task automatic check_outputs(input string where);
        int e_tone;
        bit sounding;
        sounding = (kind >= 1 && kind <= 3);
        case (kind)
            1: e_tone = 4;
            2: e_tone = 1;
`ifdef BEEP_MELODY_EN
            3: e_tone = 4 - elapsed / NT;
`else
            3: e_tone = 1;
`endif
            default: e_tone = 0;
        endcase
        chk({where, ".beep"}, int'(beep_en), int'(sounding && !mute));
        chk({where, ".tone"}, int'(tone_sel), e_tone);
        chk({where, ".busy"}, int'(busy), int'(sounding || (kind == 0 && (ph || pm || pg))));
    endtask

    task automatic tick(input string where);
        @(posedge clk_half);
        if (rst) model_reset();
        else     model_step();
        #1;
        check_outputs(where);
    endtask

    task automatic do_reset(input int hold);
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst.beep", int'(beep_en), 0);
        chk("rst.tone", int'(tone_sel), 0);
        chk("rst.busy", int'(busy), 0);
        repeat (hold) tick("rst_hold");
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        do_reset(2);
        repeat (3) tick("idle");

        // Single hit: pending on first edge, two HIT cycles at tone 4, then silent.
        hit = 1'b1; tick("hit_req");
        chk("hit_req.busy_const", int'(busy), 1);
        hit = 1'b0; tick("hit1");
        chk("hit1.tone_const", int'(tone_sel), 4);
        tick("hit2");
        chk("hit2.beep_const", int'(beep_en), 1);
        tick("hit_end");
        chk("hit_end.tone_const", int'(tone_sel), 0);
        repeat (2) tick("idle2");

        // Simultaneous hit and miss: HIT, one idle, MISS.
        hit = 1'b1; miss = 1'b1; tick("both");
        hit = 1'b0; miss = 1'b0;
        repeat (8) tick("both_play");
        chk("both.busy_done", int'(busy), 0);

        // Mute during hit: tone and timing keep going, gate stays low.
        hit = 1'b1; tick("mute_req");
        hit = 1'b0; mute = 1'b1;
        tick("mute1");
        chk("mute1.beep_const", int'(beep_en), 0);
        chk("mute1.tone_const", int'(tone_sel), 4);
        tick("mute2");
        mute = 1'b0;
        repeat (2) tick("mute_after");

        // Reset mid-playback silences at once.
        miss = 1'b1; tick("rmid_req");
        miss = 1'b0; tick("rmid_play");
        do_reset(1);
        repeat (3) tick("rmid_after");

        // Hit held high across reset release is not an edge; re-raising is.
        hit = 1'b1;
        do_reset(1);
        repeat (3) tick("held");
        chk("held.busy_const", int'(busy), 0);
        hit = 1'b0; tick("held_low");
        hit = 1'b1; tick("held_rise");
        hit = 1'b0; repeat (4) tick("held_play");

        // Miss then game over mid-playback: abort into 12-cycle game-over, then deaf.
        miss = 1'b1; tick("go_miss");
        miss = 1'b0; tick("go_m1");
        game_over = 1'b1; tick("go_edge");
        game_over = 1'b0;
        repeat (12) tick("go_over");
        tick("go_done");
        chk("go_done.busy_const", int'(busy), 0);
        hit = 1'b1; tick("done_hit");
        hit = 1'b0; repeat (3) tick("done_ignore");
        chk("done.tone_const", int'(tone_sel), 0);

        // Random traffic with occasional asynchronous resets.
        do_reset(1);
        for (int i = 0; i < 1500; i++) begin
            hit       = ($urandom_range(0, 5) == 0);
            miss      = ($urandom_range(0, 6) == 0);
            game_over = ($urandom_range(0, 60) == 0);
            mute      = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 120) == 0) do_reset($urandom_range(0, 2));
            else tick("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end

endmodule

// File: doc/beep_sched.md
BEEP_SCHED -- requirements
Module: beep_sched

Interface
REQ-001 Parameter HIT_TICKS, default 2, hit-sound duration in clk_half cycles (legal 1..15).
REQ-002 Parameter MISS_TICKS, default 4, miss-sound duration in clk_half cycles (legal 1..15).
REQ-003 Parameter NOTE_TICKS, default 3, duration of each game-over note in clk_half cycles (legal 1..15).
REQ-004 clk_half  input  1  game tick clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 hit  input  1  level from hit detector; only its rising edge is a request.
REQ-007 miss  input  1  level from mole timeout logic; only its rising edge is a request.
REQ-008 game_over  input  1  level from game timer; only its rising edge is a request.
REQ-009 mute  input  1  level; silences output without altering sequencing.
REQ-010 beep_en  output  1  buzzer gate, registered.
REQ-011 tone_sel  output  3  tone index for clock mux (0 silent, 1..4 tones), registered.
REQ-012 busy  output  1  high while any sound is playing or pending, registered.

Function
REQ-013 The block SHALL register each request input once per cycle and detect a rising edge as current 1, previous 0.
REQ-014 A detected edge SHALL set the corresponding pending flag (depth 1); a second edge while already pending SHALL be discarded.
REQ-015 The state machine SHALL have states IDLE, HIT, MISS, OVER, DONE.
REQ-016 From IDLE, with pending flags set, the next edge SHALL enter OVER if game_over pending, else HIT if hit pending, else MISS; the served flag clears on entry.
REQ-017 HIT SHALL drive tone_sel=4, beep_en=1 for exactly HIT_TICKS cycles, then return to IDLE.
REQ-018 MISS SHALL drive tone_sel=1, beep_en=1 for exactly MISS_TICKS cycles, then return to IDLE.
REQ-019 HIT and MISS SHALL NOT preempt each other; a request arriving during playback SHALL wait pending and be served from IDLE.
REQ-020 A game_over edge in any state except OVER/DONE SHALL abort current playback at the next edge, clear hit/miss pending, and enter OVER.
REQ-021 OVER SHALL last 4*NOTE_TICKS cycles, then enter DONE.
REQ-022 DONE SHALL hold beep_en=0, tone_sel=0, busy=0 and ignore all requests until rst.
REQ-023 In IDLE and DONE tone_sel SHALL be 0 and beep_en 0.
REQ-024 busy SHALL be 1 in HIT, MISS, OVER, or IDLE with any pending flag.
REQ-025 mute=1 SHALL force beep_en=0 the same cycle it is sampled; tone_sel, busy, counters and state SHALL progress unchanged.
REQ-026 The duration counter SHALL be 4 bits; a parameter value of 0 SHALL be treated as 1.
REQ-027 Simultaneous hit and miss edges SHALL serve HIT first, MISS next, with one IDLE cycle between.

Reset
REQ-028 rst=1 SHALL immediately force state IDLE, all pending flags 0, edge registers 0, counter 0, beep_en 0, tone_sel 0, busy 0.
REQ-029 Reset asserted mid-playback SHALL silence output immediately; no request survives reset.
REQ-030 An input already high at reset release SHALL NOT count as an edge.

Configuration
REQ-031 Macro BEEP_MELODY_EN defined: OVER SHALL play tone_sel 4,3,2,1, each NOTE_TICKS cycles, beep_en 1 throughout.
REQ-032 BEEP_MELODY_EN undefined: OVER SHALL hold tone_sel=1, beep_en 1 for 4*NOTE_TICKS cycles; all other behaviour identical.

Verification
REQ-033 Default params, hit pulse at cycle 10 -> pending at 10, HIT cycles 11-12 tone 4, IDLE at 13, busy 10-12.
REQ-034 hit and miss rise same cycle 5 -> HIT 6-7, IDLE 8, MISS 9-12 tone 1, busy low from 13.
REQ-035 miss at cycle 3, game_over at cycle 5 -> MISS 4-5, OVER from 6 for 12 cycles, DONE at 18; later hit ignored.
REQ-036 hit held high across rst release -> no sound; hit dropped and raised again -> one HIT.
REQ-037 mute=1 during HIT -> beep_en 0, tone_sel 4 for 2 cycles, timing unchanged.
REQ-038 Both macro builds, game_over edge -> tone_sel sequence 4,3,2,1 (3 cycles each) vs constant 1 for 12 cycles.
